// File: rtl/tdc_pkg.sv
// tdc_pkg: shared types for the multichannel time-to-digital converter
package tdc_pkg;
  typedef enum logic [1:0] {IDLE, MEASURE, REPORT} state_t;
endpackage

// File: rtl/tdc_sync_edge.sv
// tdc_sync_edge: multi-flop synchroniser with a one-cycle rising-edge strobe
module tdc_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sr;
  logic prev;
  always_ff @(posedge clk) begin
    if (reset) begin
      sr   <= '0;
      prev <= 1'b0;
    end else begin
      sr   <= {sr[SYNC_STAGES-2:0], d};
      prev <= sr[SYNC_STAGES-1];
    end
  end
  assign rise = sr[SYNC_STAGES-1] & ~prev;
endmodule

// File: rtl/tdc_multichannel.sv
// tdc_multichannel: shared-start coarse TDC with per-channel stop capture, results streamed in channel order
module tdc_multichannel
  import tdc_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int COUNT_W     = 16,
  parameter int TIMEOUT     = 1000,
  parameter int SYNC_STAGES = 2,
  localparam int CH_W       = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [NUM_CH-1:0]  stop,
  output logic               busy,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [CH_W-1:0]    res_ch,
  output logic [COUNT_W-1:0] res_delay,
  output logic               res_timeout
);
  if (NUM_CH < 1 || SYNC_STAGES < 2 || TIMEOUT < 1 ||
      longint'(TIMEOUT) > (longint'(1) << COUNT_W) - 1) begin : g_bad_params
    $error("tdc_multichannel: illegal parameter combination");
  end
  state_t state, state_nxt;
  logic [COUNT_W-1:0] cnt;
  logic [COUNT_W-1:0] dly [NUM_CH];
  logic [NUM_CH-1:0] hit, rise;
  logic [CH_W-1:0] idx;
  logic at_to, accept, last;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tdc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(clk),
      .reset(reset),
      .d(stop[i]),
      .rise(rise[i])
    );
  end
  assign at_to  = cnt == COUNT_W'(TIMEOUT);
  assign accept = res_valid & res_ready;
  assign last   = idx == CH_W'(NUM_CH - 1);
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    if (state == IDLE && start) state_nxt = MEASURE;
    else if (state == MEASURE && (&hit || at_to)) state_nxt = REPORT;
    else if (accept && last) state_nxt = IDLE;
  end
  always_comb begin
    busy        = state != IDLE;
    res_valid   = state == REPORT;
    res_ch      = res_valid ? idx : '0;
    res_timeout = res_valid && !hit[idx];
    res_delay   = !res_valid ? '0 : hit[idx] ? dly[idx] : COUNT_W'(TIMEOUT);
  end
  // counter saturates at TIMEOUT; a hit in the exit cycle still latches
  always_ff @(posedge clk) begin
    if (reset || (state == IDLE && start)) begin
      cnt <= '0;
      hit <= '0;
      idx <= '0;
      for (int c = 0; c < NUM_CH; c++) dly[c] <= '0;
    end else if (state == MEASURE) begin
      if (!at_to) cnt <= cnt + 1'b1;
      for (int c = 0; c < NUM_CH; c++)
        if (rise[c] && !hit[c]) begin
          hit[c] <= 1'b1;
          dly[c] <= cnt;
        end
    end else if (accept) begin
      idx <= last ? '0 : idx + 1'b1;
    end
  end
endmodule

// File: doc/tdc_multichannel.md
# tdc_multichannel

Multi-channel time-to-digital converter, the parametrised successor to the single-line TDC. One shared `start` pulse arms a coarse cycle counter; each of `NUM_CH` asynchronous `stop` inputs is synchronised and edge-detected, and the counter value at its first rising edge is latched. When all channels have hit, or the counter reaches `TIMEOUT`, the block streams one result per channel, in channel order, over a valid/ready interface to the UART/reporting logic.

## Interface
- `NUM_CH`, 4: number of stop channels; ≥1.
- `COUNT_W`, 16: coarse counter and result width.
- `TIMEOUT`, 1000: terminal count; must satisfy 1 ≤ `TIMEOUT` ≤ 2^`COUNT_W`−1; elaboration error otherwise.
- `SYNC_STAGES`, 2: synchroniser depth on each stop input; ≥2.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  measurement start; sampled only in IDLE.
- `stop`  in  `NUM_CH`  asynchronous stop events, one bit per channel.
- `busy`  out  1  high whenever state ≠ IDLE.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts result.
- `res_ch`  out  max(1,$clog2(`NUM_CH`))  channel index of current result.
- `res_delay`  out  `COUNT_W`  measured delay in cycles.
- `res_timeout`  out  1  channel saw no stop edge before timeout.

## Operation
- FSM states: IDLE, MEASURE, REPORT.
- IDLE: `start`=1 at an edge → MEASURE; counter ← 0; all hit flags and delay registers ← 0.
- MEASURE: counter increments by 1 each cycle and never wraps. A channel whose synchronised stop shows a rising edge, with its hit flag clear, latches the current counter value and sets its hit flag. Later edges on a hit channel are ignored.
- MEASURE exit → REPORT with index ← 0 when either condition holds:
  - all registered hit flags are set; or
  - counter == `TIMEOUT`. A hit occurring in that same cycle is still latched.
- REPORT: `res_valid`=1; `res_ch`=index; `res_delay`/`res_timeout` come from that channel's registers.
  - Unhit channel: `res_delay`=`TIMEOUT`, `res_timeout`=1.
  - On `res_valid`&`res_ready`: index increments; after index `NUM_CH`−1 is accepted → IDLE.
- `start` is ignored in MEASURE and REPORT.
- Synchroniser and edge-detect history run in every state. A stop already high at start produces no hit until it falls and rises again.
- Reset value of every output: `busy`=0, `res_valid`=0, `res_ch`=0, `res_delay`=0, `res_timeout`=0.
- Reset mid-operation:
  - FSM → IDLE; counter, flags, delays and sync chains cleared.
  - Reset wins over a simultaneous `start`.

## Timing
- `start` sampled high at edge S → after edge S+j, counter = j.
- `stop[i]` first sampled high at edge P (P>S) → latched delay = (P−S)+`SYNC_STAGES`−1, written at edge P+`SYNC_STAGES`.
- All-hit exit: REPORT entered at the edge after the last hit flag is registered.
- Timeout exit: REPORT entered at the edge after counter == `TIMEOUT`.
- `res_valid` goes high in the first REPORT cycle.
- Results are held stable while `res_valid`&!`res_ready`. With ready held high, one result is issued per cycle.
- `busy` falls at the edge that accepts the last result.

## Structure
- Package `tdc_pkg`: state enum typedef (IDLE/MEASURE/REPORT).
- Sub-module `tdc_sync_edge`: `SYNC_STAGES`-deep synchroniser plus previous-value flop, emitting a one-cycle rising-edge strobe; instantiated `NUM_CH` times.
- Top level contains the FSM, counter, per-channel hit/delay register arrays and the result mux.

## Test plan
All scenarios use `NUM_CH`=4, `COUNT_W`=16, `TIMEOUT`=100, `SYNC_STAGES`=2.

- All channels hit:
  - Stimulus: `start` at edge 10; stop[2] high at 12, stop[0] at 15, stop[1] at 20, stop[3] at 30; `res_ready`=1.
  - Response: ch0=6, ch1=11, ch2=3, ch3=21, all `res_timeout`=0, on four consecutive valid cycles; `busy` falls after ch3 is accepted.
- Timeout:
  - Stimulus: only stop[1] high at S+5.
  - Response: ch1 delay=6, timeout=0; ch0/2/3 delay=100, timeout=1; REPORT entered at edge S+101.
- Backpressure:
  - Stimulus: `res_ready` low for 3 cycles at ch0, then toggled.
  - Response: `res_valid`/`res_ch`/`res_delay` stable while stalled; no result lost or duplicated; order 0,1,2,3.
- Pre-high and repeated stop:
  - Stimulus: stop[2] high before `start` and held; stop[0] pulses twice (at S+4 and S+9).
  - Response: ch2 times out; ch0 reports 5 (first edge only).
- Start ignored, then reset mid-measure:
  - Stimulus: `start` reasserted in MEASURE and REPORT; later, `reset` at S+7 in MEASURE; then a fresh `start`.
  - Response: extra starts have no effect; after reset `busy`=0 and `res_valid`=0 at the next edge; the fresh `start` measures correctly from counter 0.
